// File: rtl/i2c_sht40_responder.sv
// i2c_sht40_responder: I2C target emulating an SHT40 (address ACK, measure command, busy timer, 6-byte CRC'd read).
module i2c_sht40_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h44,
    parameter logic [7:0] MEAS_CMD    = 8'hFD,
    parameter int         MEAS_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Scl_In,
    input  logic        Sda_In,
    output logic        Sda_Out,
    input  logic [15:0] Temp_Data,
    input  logic [15:0] Rh_Data,
    output logic        Cmd_Valid,
    output logic [7:0]  Cmd_Byte,
    output logic        Meas_Busy,
    output logic        Resp_Ready
);
    localparam int TW = $clog2(MEAS_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_BYTE, TX_ACK, IGNORE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     scl_q, sda_in_q;
    logic [3:0]     cnt_q, cnt_d;
    logic [6:0]     shift_q, shift_d;
    logic [2:0]     idx_q, idx_d;
    logic           rw_q, rw_d, sda_q, sda_d, cv_q, cv_d, busy_q, busy_d, ready_q, ready_d;
    logic [7:0]     cmd_q, cmd_d, tx_byte, crc_t, crc_rh;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    temp_q, temp_d, rh_q, rh_d;
    logic           scl_s, scl_h, sda_s, sda_h, scl_rise, scl_fall, start, stop;
    logic [7:0]     rx_byte;

    function automatic logic [7:0] crc8(input logic [15:0] w);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 15; i >= 0; i--)
            c = (c[7] ^ w[i]) ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
        return c;
    endfunction

    // [1] is the synchronized level, [2] its one-cycle history
    assign scl_s    = scl_q[1];
    assign scl_h    = scl_q[2];
    assign sda_s    = sda_in_q[1];
    assign sda_h    = sda_in_q[2];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;
    assign rx_byte  = {shift_q, sda_s};
    assign crc_t    = crc8(temp_q);
    assign crc_rh   = crc8(rh_q);

    always_comb begin
        case (idx_q)
            3'd0:    tx_byte = temp_q[15:8];
            3'd1:    tx_byte = temp_q[7:0];
            3'd2:    tx_byte = crc_t;
            3'd3:    tx_byte = rh_q[15:8];
            3'd4:    tx_byte = rh_q[7:0];
            3'd5:    tx_byte = crc_rh;
            default: tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        sda_d   = sda_q;
        cv_d    = 1'b0;
        cmd_d   = cmd_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        timer_d = timer_q;
        temp_d  = temp_q;
        rh_d    = rh_q;
        if (busy_q) begin
            timer_d = timer_q - TW'(1);
            if (timer_q == TW'(1)) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                temp_d  = Temp_Data;
                rh_d    = Rh_Data;
            end
        end
        if (start) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            sda_d   = 1'b1;
        end else if (stop) begin
            state_d = IDLE;
            sda_d   = 1'b1;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = rx_byte[6:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        idx_d   = 3'd0;
                        rw_d    = sda_s;
                        state_d = (rx_byte[7:1] == TARGET_ADDR && (!sda_s || ready_q)) ? ADDR_ACK : IGNORE;
                    end
                end
                // cnt 0: first fall starts the ACK; cnt 1: second fall ends it
                ADDR_ACK: if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        sda_d = 1'b0;
                        cnt_d = 4'd1;
                    end else begin
                        sda_d   = rw_q ? tx_byte[7] : 1'b1;
                        cnt_d   = rw_q ? 4'd1 : 4'd0;
                        state_d = rw_q ? TX_BYTE : CMD;
                    end
                end
                CMD: if (scl_rise) begin
                    shift_d = rx_byte[6:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        cmd_d   = rx_byte;
                        cv_d    = 1'b1;
                        state_d = CMD_ACK;
                        if (rx_byte == MEAS_CMD) begin
                            ready_d = 1'b0;
                            busy_d  = 1'b1;
                            timer_d = TW'(MEAS_CYCLES);
                        end
                    end
                end
                CMD_ACK: if (scl_fall) begin
                    sda_d   = cnt_q != 4'd0;
                    cnt_d   = 4'd1;
                    state_d = (cnt_q == 4'd0) ? CMD_ACK : IGNORE;
                end
                TX_BYTE: if (scl_fall) begin
                    sda_d   = (cnt_q == 4'd8) ? 1'b1 : tx_byte[3'd7 - cnt_q[2:0]];
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd8) ? TX_ACK : TX_BYTE;
                end
                TX_ACK: if (scl_rise) begin
                    if (sda_s) begin
                        state_d = IGNORE;
                        ready_d = (idx_q == 3'd5) ? 1'b0 : ready_q;
                    end else begin
                        idx_d   = (idx_q == 3'd6) ? 3'd6 : idx_q + 3'd1;
                        cnt_d   = 4'd0;
                        state_d = TX_BYTE;
                    end
                end
                default: sda_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q    <= 3'b111;
            sda_in_q <= 3'b111;
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            shift_q  <= 7'd0;
            idx_q    <= 3'd0;
            rw_q     <= 1'b0;
            sda_q    <= 1'b1;
            cv_q     <= 1'b0;
            cmd_q    <= 8'd0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            timer_q  <= '0;
            temp_q   <= 16'd0;
            rh_q     <= 16'd0;
        end else begin
            scl_q    <= {scl_q[1:0], Scl_In};
            sda_in_q <= {sda_in_q[1:0], Sda_In};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            rw_q     <= rw_d;
            sda_q    <= sda_d;
            cv_q     <= cv_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            timer_q  <= timer_d;
            temp_q   <= temp_d;
            rh_q     <= rh_d;
        end
    end

    assign Sda_Out    = sda_q;
    assign Cmd_Valid  = cv_q;
    assign Cmd_Byte   = cmd_q;
    assign Meas_Busy  = busy_q;
    assign Resp_Ready = ready_q;
endmodule

// File: tb/tb_i2c_sht40_responder.sv
// tb_i2c_sht40_responder: bit-banged I2C master driving the SHT40 responder, checked against a response/readiness model.
module tb_i2c_sht40_responder;
    logic        clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic [15:0] temp_in = 16'd0, rh_in = 16'd0;
    logic        sda_out, cmd_valid, meas_busy, resp_ready, sda_bus;
    logic [7:0]  cmd_byte;
    int          checks = 0, failures = 0;
    int          low_cnt = 0, cv_cnt = 0, busy_cnt = 0;
    logic [15:0] m_t = 16'd0, m_rh = 16'd0;
    logic        m_ready = 1'b0;

    assign sda_bus = sda_m & sda_out;
    always #5 clk = ~clk;

    i2c_sht40_responder dut (
        .clk(clk), .rst_n(rst_n), .Scl_In(scl_m), .Sda_In(sda_bus), .Sda_Out(sda_out),
        .Temp_Data(temp_in), .Rh_Data(rh_in), .Cmd_Valid(cmd_valid), .Cmd_Byte(cmd_byte),
        .Meas_Busy(meas_busy), .Resp_Ready(resp_ready)
    );

    // free-running event counters; tests compare deltas
    always @(negedge clk) begin
        if (!sda_out) low_cnt++;
        if (cmd_valid) cv_cnt++;
        if (meas_busy) busy_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [15:0] w);
        logic [7:0] c = 8'hFF;
        logic [7:0] by [2];
        by[0] = w[15:8];
        by[1] = w[7:0];
        for (int k = 0; k < 2; k++) begin
            c = c ^ by[k];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] r [6];
        r[0] = m_t[15:8];
        r[1] = m_t[7:0];
        r[2] = crc_ref(m_t);
        r[3] = m_rh[15:8];
        r[4] = m_rh[7:0];
        r[5] = crc_ref(m_rh);
        return (i > 5) ? 8'hFF : r[i];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b0; tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b1; tick(10);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(10);
            scl_m = 1'b1; tick(20);
            scl_m = 1'b0; tick(10);
        end
    endtask

    task automatic wr(input logic [7:0] b, output logic a);
        send_bits(b);
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(10);
        a = sda_bus;  tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic rd(input logic nack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(10);
            scl_m = 1'b1; tick(10);
            b[i] = sda_bus; tick(10);
            scl_m = 1'b0;
        end
        tick(10);
        sda_m = nack; tick(10);
        scl_m = 1'b1; tick(20);
        scl_m = 1'b0; tick(10);
        sda_m = 1'b1;
    endtask

    // START + 0x89 + n bytes (master NACKs the last); caller ends with STOP or repeated START
    task automatic read_resp(input int n);
        logic       a;
        logic [7:0] b;
        i2c_start;
        wr(8'h89, a);
        check("rd_addr_ack", a, !m_ready);
        if (m_ready) begin
            for (int i = 0; i < n; i++) begin
                rd(i == n - 1, b);
                check("rd_byte", b, exp_byte(i));
            end
            if (n == 6) m_ready = 1'b0;
            check("rd_ready_after", resp_ready, m_ready);
            check("rd_sda_released", sda_out, 1);
        end
    endtask

    task automatic meas(input logic [15:0] t, input logic [15:0] h, input logic probe);
        logic       a;
        logic [7:0] b;
        int         b0, c0, l0, n;
        temp_in = t;
        rh_in   = h;
        b0 = busy_cnt;
        c0 = cv_cnt;
        i2c_start;
        wr(8'h88, a);
        check("meas_addr_ack", a, 0);
        wr(8'hFD, a);
        check("meas_cmd_ack", a, 0);
        i2c_stop;
        m_ready = 1'b0;
        check("meas_cmd_byte", cmd_byte, 8'hFD);
        check("meas_cv_once", cv_cnt - c0, 1);
        if (probe) begin
            l0 = low_cnt;
            i2c_start;
            wr(8'h89, a);
            check("busy_addr_nack", a, 1);
            rd(1'b1, b);
            check("busy_no_data", b, 8'hFF);
            i2c_stop;
            check("busy_sda_quiet", low_cnt - l0, 0);
        end
        n = 0;
        while (meas_busy && n < 3000) begin
            tick(1);
            n++;
        end
        check("busy_timeout", meas_busy, 0);
        check("busy_len", busy_cnt - b0, 1000);
        m_t = t;
        m_rh = h;
        m_ready = 1'b1;
        check("meas_ready", resp_ready, m_ready);
        temp_in = 16'($urandom);
        rh_in   = 16'($urandom);
    endtask

    initial begin
        logic       a;
        logic [7:0] c, x;
        int         l0, c0, b0, n;
        tick(5);
        check("rst_sda", sda_out, 1);
        check("rst_cv", cmd_valid, 0);
        check("rst_cmd", cmd_byte, 0);
        check("rst_busy", meas_busy, 0);
        check("rst_ready", resp_ready, 0);
        rst_n = 1'b1;
        tick(5);

        meas(16'hBEEF, 16'hBEEF, 1'b0);
        read_resp(6);
        i2c_stop;

        meas(16'($urandom), 16'($urandom), 1'b1);
        read_resp(2);
        read_resp(8);
        i2c_stop;
        check("rs_ready_kept", resp_ready, m_ready);

        i2c_start;
        send_bits(8'h89);
        tick(10);
        check("ack_driven", sda_out, 0);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_sda", sda_out, 1);
        check("mid_rst_cv", cmd_valid, 0);
        check("mid_rst_cmd", cmd_byte, 0);
        check("mid_rst_busy", meas_busy, 0);
        check("mid_rst_ready", resp_ready, 0);
        m_ready = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(10);

        l0 = low_cnt;
        c0 = cv_cnt;
        b0 = busy_cnt;
        i2c_start;
        wr(8'h8A, a);
        check("wrong_addr_nack", a, 1);
        wr(8'hFD, a);
        check("wrong_cmd_nack", a, 1);
        i2c_stop;
        check("wrong_sda_quiet", low_cnt - l0, 0);
        check("wrong_no_cv", cv_cnt - c0, 0);
        check("wrong_no_busy", busy_cnt - b0, 0);

        for (int i = 0; i < 3; i++) begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'hFD) c = 8'h12;
            x = 8'($urandom);
            c0 = cv_cnt;
            b0 = busy_cnt;
            i2c_start;
            wr(8'h88, a);
            check("cmd_addr_ack", a, 0);
            wr(c, a);
            check("cmd_ack", a, 0);
            wr(x, a);
            check("cmd_extra_nack", a, 1);
            i2c_stop;
            check("cmd_byte", cmd_byte, c);
            check("cmd_cv_once", cv_cnt - c0, 1);
            check("cmd_no_busy", busy_cnt - b0, 0);
            check("cmd_ready_kept", resp_ready, m_ready);
            if (i == 1) begin
                meas(16'($urandom), 16'($urandom), 1'b0);
            end
        end

        for (int i = 0; i < 3; i++) begin
            meas(16'($urandom), 16'($urandom), i == 0);
            n = $urandom_range(1, 8);
            read_resp(n);
            if (m_ready) read_resp(6);
            i2c_stop;
            check("loop_ready", resp_ready, m_ready);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
